// File: rtl/keypad_scanner_fifo.sv
// keypad_scanner_fifo
// Scans an active-low keypad matrix one column at a time, samples the rows
// through a two-flop synchroniser, debounces whole-frame results and queues
// press/release events in a first-word-fall-through FIFO (valid/ready).
// The consumer maps the raw key index (row_idx*COLS + col_idx) to symbols.
module keypad_scanner_fifo #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_INTERVAL   = 100_000,
    parameter int SETTLE_CYCLES   = 5_000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int CODE_W          = $clog2(ROWS*COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CODE_W-1:0] evt_code,
    output logic              evt_release,
    output logic              key_held,
    output logic [CODE_W-1:0] held_code,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam int ROW_W   = $clog2(ROWS);
    localparam int COL_W   = $clog2(COLS);
    localparam int DWELL_W = $clog2(SCAN_INTERVAL);
    localparam int CNT_W   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_SCAN} scan_state_t;

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_kind_t;

    // Result of one full frame; code is forced to zero unless kind is RES_KEY
    // so that whole-struct comparisons are meaningful.
    typedef struct packed {
        res_kind_t         kind;
        logic [CODE_W-1:0] code;
    } frame_res_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              is_release;
    } evt_t;

    // ------------------------------------------------------------------
    // Row synchroniser
    // ------------------------------------------------------------------
    logic [ROWS-1:0] row_meta;
    logic [ROWS-1:0] row_sync;

    // Two-flop synchroniser for the asynchronous rows; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            // NOTE: non-blocking assignments make row_sync take the previous
            // row_meta, giving two real flops instead of one.
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    scan_state_t      state;
    scan_state_t      state_nxt;
    logic             scanning;
    logic [COL_W-1:0] col_idx;
    logic [DWELL_W-1:0] dwell_cnt;

    assign scanning = (state == S_SCAN) && enable;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state: scanning runs only while enable is high.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no
        // latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:  if (enable)  state_nxt = S_SCAN;
            S_SCAN:  if (!enable) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: the selected column is driven low while scanning.
    always_comb begin
        col = '1;
        if (state == S_SCAN) col = ~(COLS'(1) << col_idx);
    end

    // Dwell counter and column index; both park at zero when not scanning so
    // a restart always begins at column 0, dwell 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_idx   <= '0;
            dwell_cnt <= '0;
        end else if (!scanning) begin
            col_idx   <= '0;
            dwell_cnt <= '0;
        end else if (dwell_cnt == DWELL_W'(SCAN_INTERVAL - 1)) begin
            dwell_cnt <= '0;
            col_idx   <= (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
        end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame accumulation
    // ------------------------------------------------------------------
    logic              sample_en;
    logic [1:0]        col_hits;   // low rows in this column, saturates at 2
    logic [ROW_W-1:0]  hit_row;
    logic [CODE_W-1:0] hit_code;
    logic [1:0]        acc_hits;   // low points in this frame, saturates at 2
    logic [CODE_W-1:0] acc_code;
    logic [2:0]        hit_sum;
    logic              frame_done;

    assign sample_en = scanning && (dwell_cnt == DWELL_W'(SETTLE_CYCLES));
    assign hit_code  = CODE_W'(int'(hit_row) * COLS + int'(col_idx));
    assign hit_sum   = {1'b0, acc_hits} + {1'b0, col_hits};

    // Count low rows in the sampled column and locate the first one.
    always_comb begin
        col_hits = '0;
        hit_row  = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!row_sync[r]) begin
                if (col_hits == 2'd0) hit_row = ROW_W'(r);
                if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
            end
        end
    end

    // Accumulate samples over a frame; frame_done marks the cycle after the
    // last column's sample, where the accumulator is consumed and cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hits   <= '0;
            acc_code   <= '0;
            frame_done <= 1'b0;
        end else if (!scanning) begin
            acc_hits   <= '0;
            acc_code   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= sample_en && (col_idx == COL_W'(COLS - 1));
            if (frame_done) begin
                acc_hits <= '0;
                acc_code <= '0;
            end else if (sample_en && col_hits != 2'd0) begin
                if (acc_hits == 2'd0) acc_code <= hit_code;
                acc_hits <= (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Debounce and commit
    // ------------------------------------------------------------------
    frame_res_t        frame_res;
    frame_res_t        committed_res;
    frame_res_t        cand;
    logic [CNT_W-1:0]  stable_cnt;
    logic [CNT_W-1:0]  stable_nxt;
    logic              commit;
    logic              pend_press;
    logic [CODE_W-1:0] pend_code;

    // Classify the finished frame and the current committed state.
    always_comb begin
        frame_res.kind = RES_NONE;
        frame_res.code = '0;
        if (acc_hits == 2'd1) begin
            frame_res.kind = RES_KEY;
            frame_res.code = acc_code;
        end else if (acc_hits == 2'd2) begin
            frame_res.kind = RES_MULTI;
        end
        committed_res.kind = key_held ? RES_KEY : RES_NONE;
        committed_res.code = held_code;
    end

    // Stability count and commit decision; MULTI never commits.
    always_comb begin
        stable_nxt = CNT_W'(1);
        if (frame_res == cand) begin
            stable_nxt = (stable_cnt == CNT_W'(DEBOUNCE_FRAMES)) ? stable_cnt
                                                                  : stable_cnt + CNT_W'(1);
        end
        commit = scanning && frame_done && (frame_res.kind != RES_MULTI) &&
                 (stable_nxt == CNT_W'(DEBOUNCE_FRAMES)) && (frame_res != committed_res);
    end

    // Candidate (previous frame result) and its stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand       <= '{kind: RES_NONE, code: '0};
            stable_cnt <= '0;
        end else if (!scanning) begin
            cand       <= '{kind: RES_NONE, code: '0};
            stable_cnt <= '0;
        end else if (frame_done) begin
            cand       <= frame_res;
            stable_cnt <= stable_nxt;
        end
    end

    // Committed key and the deferred press of a key-to-key change; disabling
    // the scanner drops both without emitting a release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_held   <= 1'b0;
            held_code  <= '0;
            pend_press <= 1'b0;
            pend_code  <= '0;
        end else if (!scanning) begin
            key_held   <= 1'b0;
            held_code  <= '0;
            pend_press <= 1'b0;
            pend_code  <= '0;
        end else begin
            pend_press <= commit && key_held && (frame_res.kind == RES_KEY);
            if (commit) begin
                pend_code <= frame_res.code;
                key_held  <= (frame_res.kind == RES_KEY);
                held_code <= frame_res.code;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic             push_valid;
    evt_t             push_evt;
    evt_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             drop;
    evt_t             head;
    evt_t             last_evt;

    // Event to push: the deferred press takes the cycle after a release.
    always_comb begin
        push_valid = 1'b0;
        push_evt   = '0;
        if (scanning && pend_press) begin
            push_valid          = 1'b1;
            push_evt.code       = pend_code;
            push_evt.is_release = 1'b0;
        end else if (commit) begin
            push_valid          = 1'b1;
            push_evt.code       = key_held ? held_code : frame_res.code;
            push_evt.is_release = key_held;
        end
    end

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign pop        = !fifo_empty && evt_ready;
    assign push_ok    = push_valid && (!fifo_full || pop);
    assign drop       = push_valid && fifo_full && !pop;

    // Event storage, written on accepted pushes.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; occupancy is
        // tracked by count, so stale entries are never presented.
        if (push_ok) mem[wr_ptr] <= push_evt;
    end

    // Pointers and occupancy; a push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head        = fifo_empty ? last_evt : mem[rd_ptr];
    assign evt_valid   = !fifo_empty;
    assign evt_code    = head.code;
    assign evt_release = head.is_release;

    // Remember the presented event so the outputs hold once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_evt <= '0;
        else        last_evt <= head;
    end

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_keypad_scanner_fifo.sv
// tb_keypad_scanner_fifo
// Directed bench: a combinational keypad model drives the rows from the
// column drive and a set of pressed keys; a monitor logs every consumed event.
module tb_keypad_scanner_fifo;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_code;
    logic        evt_release;
    logic        key_held;
    logic [3:0]  held_code;
    logic        overflow;
    logic        clr_overflow;

    logic [15:0] keys;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic [3:0] code;
        logic       rel;
        int         cyc;
    } evt_log_t;

    evt_log_t log_q[$];

    keypad_scanner_fifo #(
        .ROWS(4), .COLS(4), .SCAN_INTERVAL(8), .SETTLE_CYCLES(4),
        .DEBOUNCE_FRAMES(2), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .row(row), .col(col),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_release(evt_release), .key_held(key_held), .held_code(held_code),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad: row r reads low when a pressed key (r,c) sits on a driven column.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4 + c] && !col[c]) row[r] = 1'b0;
    end

    // Log each event the consumer accepts.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready)
            log_q.push_back('{evt_code, evt_release, cyc});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_evt(input string tag, input int idx, input logic [3:0] code, input logic rel);
        if (idx < log_q.size()) begin
            check({tag, "_code"}, log_q[idx].code, code);
            check({tag, "_rel"}, log_q[idx].rel, rel);
        end else begin
            check({tag, "_missing"}, log_q.size(), idx + 1);
        end
    endtask

    // Advance to the cycle in which column 0 has just been driven low.
    task automatic wait_frame_start();
        int n;
        n = 0;
        while (col == 4'b1110 && n < 200) begin @(posedge clk); #1; n++; end
        while (col != 4'b1110 && n < 200) begin @(posedge clk); #1; n++; end
        check("frame_timeout", n < 200, 1);
    endtask

    task automatic wait_frames(input int n);
        for (int k = 0; k < n; k++) wait_frame_start();
    endtask

    initial begin
        logic [3:0] exp_col;

        rst_n = 1'b0; enable = 1'b1; evt_ready = 1'b1; clr_overflow = 1'b0; keys = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", col, 4'b1111);
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_release", evt_release, 0);
        check("rst_held", key_held, 0);
        check("rst_held_code", held_code, 0);
        check("rst_overflow", overflow, 0);

        // Column sequence: 8 cycles per column, wrapping to column 0.
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 33; i++) begin
            exp_col = 4'b1111 ^ (4'b0001 << ((i / 8) % 4));
            check("scan_col", col, exp_col);
            @(posedge clk); #1;
        end
        check("scan_no_evt", evt_valid, 0);

        // Press and release of key 6 (row 1, column 2).
        wait_frame_start();
        keys = 16'h0040;
        wait_frames(2);
        check("press_held", key_held, 1);
        check("press_held_code", held_code, 6);
        wait_frames(1);
        keys = '0;
        wait_frames(2);
        check("rel_held", key_held, 0);
        check("rel_held_code", held_code, 0);
        wait_frames(1);
        check("pr_count", log_q.size(), 2);
        check_evt("pr_ev0", 0, 4'd6, 1'b0);
        check_evt("pr_ev1", 1, 4'd6, 1'b1);

        // Bounce: key toggles every frame, never stable long enough.
        log_q.delete();
        for (int f = 0; f < 6; f++) begin
            keys = (f % 2 == 0) ? 16'h0040 : 16'h0000;
            wait_frames(1);
            check("bounce_held", key_held, 0);
        end
        keys = '0;
        wait_frames(2);
        check("bounce_count", log_q.size(), 0);

        // Multi-key, then roll-over from key 6 to key 9.
        log_q.delete();
        keys = 16'h0240;
        wait_frames(3);
        check("multi_count", log_q.size(), 0);
        check("multi_held", key_held, 0);
        keys = 16'h0040;
        wait_frames(2);
        check("roll_held6", held_code, 6);
        keys = 16'h0200;
        wait_frames(2);
        check("roll_held", key_held, 1);
        check("roll_held9", held_code, 9);
        check("roll_count", log_q.size(), 3);
        check_evt("roll_ev0", 0, 4'd6, 1'b0);
        check_evt("roll_ev1", 1, 4'd6, 1'b1);
        check_evt("roll_ev2", 2, 4'd9, 1'b0);
        if (log_q.size() >= 3) check("roll_gap", log_q[2].cyc - log_q[1].cyc, 1);
        keys = '0;
        wait_frames(2);
        check("roll_count_end", log_q.size(), 4);
        check_evt("roll_ev3", 3, 4'd9, 1'b1);

        // Backpressure: three commits into a two-entry queue.
        log_q.delete();
        evt_ready = 1'b0;
        keys = 16'h0040; wait_frames(2);
        keys = 16'h0000; wait_frames(2);
        keys = 16'h0040; wait_frames(2);
        check("bp_valid", evt_valid, 1);
        check("bp_head_code", evt_code, 6);
        check("bp_head_rel", evt_release, 0);
        check("bp_overflow", overflow, 1);
        check("bp_held", key_held, 1);
        check("bp_no_pop", log_q.size(), 0);
        evt_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("drain_count", log_q.size(), 2);
        check_evt("drain_ev0", 0, 4'd6, 1'b0);
        check_evt("drain_ev1", 1, 4'd6, 1'b1);
        check("drain_valid", evt_valid, 0);
        check("drain_hold_code", evt_code, 6);
        check("drain_hold_rel", evt_release, 1);
        check("drain_overflow", overflow, 1);
        clr_overflow = 1'b1;
        @(posedge clk); #1;
        clr_overflow = 1'b0;
        check("clr_overflow", overflow, 0);

        // Disable while key 6 is held: silent clear, no release event.
        log_q.delete();
        enable = 1'b0;
        @(posedge clk); #1;
        check("dis_col", col, 4'b1111);
        check("dis_held", key_held, 0);
        check("dis_held_code", held_code, 0);
        repeat (40) begin @(posedge clk); #1; end
        check("dis_no_evt", log_q.size(), 0);
        check("dis_valid", evt_valid, 0);
        enable = 1'b1;
        @(posedge clk); #1;
        check("en_col0", col, 4'b1110);
        evt_ready = 1'b0;
        wait_frames(2);
        check("en_held", key_held, 1);
        check("en_valid", evt_valid, 1);
        check("en_code", evt_code, 6);

        // Asynchronous reset mid-dwell, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_col", col, 4'b1111);
        check("arst_valid", evt_valid, 0);
        check("arst_code", evt_code, 0);
        check("arst_release", evt_release, 0);
        check("arst_held", key_held, 0);
        check("arst_held_code", held_code, 0);
        check("arst_overflow", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
